// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Bundles the Imem port, redirect inputs and decode handshake
//                of the instruction fetch stage. master = fetch unit side,
//                slave = surrounding pipeline / Imem side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int ADDRESS_SIZE = 32
);
    // Imem side
    logic [0:ADDRESS_SIZE-1] imem_address;
    logic [0:ADDRESS_SIZE-1] imem_instruction;

    // Pipeline control
    logic                    fetch_enable;
    logic                    redirect_valid;
    logic [0:ADDRESS_SIZE-1] redirect_target;

    // Decode handshake
    logic                    id_valid;
    logic                    id_ready;
    logic [0:ADDRESS_SIZE-1] id_instruction;
    logic [0:ADDRESS_SIZE-1] id_pc;

    // Status
    logic                    fetch_fault;

    modport master (
        output imem_address,
        input  imem_instruction,
        input  fetch_enable,
        input  redirect_valid,
        input  redirect_target,
        output id_valid,
        input  id_ready,
        output id_instruction,
        output id_pc,
        output fetch_fault
    );

    modport slave (
        input  imem_address,
        output imem_instruction,
        output fetch_enable,
        output redirect_valid,
        output redirect_target,
        input  id_valid,
        output id_ready,
        input  id_instruction,
        input  id_pc,
        input  fetch_fault
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Owns the PC, addresses Imem, keeps a
//                2-deep FIFO of {pc, instruction} toward decode and handles
//                branch/jump redirects including misaligned-target faults.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                      ADDRESS_SIZE = 32,
    parameter logic [0:ADDRESS_SIZE-1] BOOT_ADDRESS = 'h1000,
    parameter int                      PC_STEP      = 4
) (
    input  wire logic   clk,
    input  wire logic   reset,
    fetch_unit_if.master bus
);

    localparam logic [0:ADDRESS_SIZE-1] c_PC_STEP     = ADDRESS_SIZE'(PC_STEP);
    localparam logic [0:0]              c_STATE_RUN   = 1'b0;
    localparam logic [0:0]              c_STATE_FAULT = 1'b1;
    localparam logic [1:0]              c_DEPTH       = 2'd2;

    // Architectural state
    logic [0:ADDRESS_SIZE-1] r_pc;
    logic [0:0]              r_state;
    logic                    r_fault;

    // Shift-style FIFO: head entry always drives decode, so when the buffer
    // drains or is flushed the last head value simply stays visible.
    logic [1:0]              r_count;
    logic [0:ADDRESS_SIZE-1] r_head_pc;
    logic [0:ADDRESS_SIZE-1] r_head_ins;
    logic [0:ADDRESS_SIZE-1] r_tail_pc;
    logic [0:ADDRESS_SIZE-1] r_tail_ins;

    logic                    w_valid;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_target_aligned;
    logic [0:ADDRESS_SIZE-1] w_pc_next;

    // Handshake, push qualification and target alignment decode
    always_comb begin
        w_valid          = (r_count != 2'd0);
        w_pop            = w_valid & bus.id_ready;
        w_push           = (r_state == c_STATE_RUN) & bus.fetch_enable & ~bus.redirect_valid
                           & ((r_count != c_DEPTH) | w_pop);
        w_target_aligned = (bus.redirect_target[ADDRESS_SIZE-2:ADDRESS_SIZE-1] == 2'b00);
        w_pc_next        = r_pc + c_PC_STEP;
    end

    // PC, run/fault state and sticky fault flag; redirect outranks fetching
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= BOOT_ADDRESS;
            r_state <= c_STATE_RUN;
            r_fault <= 1'b0;
        end else if (bus.redirect_valid) begin
            if (w_target_aligned) begin
                r_pc    <= bus.redirect_target;
                r_state <= c_STATE_RUN;
                r_fault <= 1'b0;
            end else begin
                // Misaligned target: PC is left alone, fetching stops
                r_state <= c_STATE_FAULT;
                r_fault <= 1'b1;
            end
        end else if (w_push) begin
            r_pc <= w_pc_next;
        end
    end

    // Occupancy count; a redirect flushes and overrides any pending pop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 2'd0;
        end else if (bus.redirect_valid) begin
            r_count <= 2'd0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            r_count <= r_count - 2'd1;
        end
    end

    // FIFO storage; contents are kept on flush so decode outputs hold
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head_pc  <= '0;
            r_head_ins <= '0;
            r_tail_pc  <= '0;
            r_tail_ins <= '0;
        end else if (!bus.redirect_valid) begin
            if (w_pop) begin
                if (r_count == c_DEPTH) begin
                    // Two entries: advance tail to head, refill tail if pushing
                    r_head_pc  <= r_tail_pc;
                    r_head_ins <= r_tail_ins;
                    if (w_push) begin
                        r_tail_pc  <= r_pc;
                        r_tail_ins <= bus.imem_instruction;
                    end
                end else if (w_push) begin
                    // Single entry popped and replaced in the same cycle
                    r_head_pc  <= r_pc;
                    r_head_ins <= bus.imem_instruction;
                end
            end else if (w_push) begin
                if (r_count == 2'd0) begin
                    r_head_pc  <= r_pc;
                    r_head_ins <= bus.imem_instruction;
                end else begin
                    r_tail_pc  <= r_pc;
                    r_tail_ins <= bus.imem_instruction;
                end
            end
        end
    end

    // Outputs: Imem address tracks the PC register directly
    assign bus.imem_address   = r_pc;
    assign bus.id_valid       = w_valid;
    assign bus.id_instruction = r_head_ins;
    assign bus.id_pc          = r_head_pc;
    assign bus.fetch_fault    = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit: per-cycle vector table
//                for reset, stall, redirect, fault and wrap cases, then a
//                random-stall stream checked against an expected-PC queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int c_AW = 32;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    fetch_unit_if #(.ADDRESS_SIZE(c_AW)) bus ();

    fetch_unit #(
        .ADDRESS_SIZE (c_AW),
        .BOOT_ADDRESS (32'h1000),
        .PC_STEP      (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Imem contents: a cheap address-dependent pattern
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    assign bus.imem_instruction = imem(bus.imem_address);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        rv;
        logic [31:0] tgt;
        logic        rdy;
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        flt;
        logic [31:0] addr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, en, rv, input logic [31:0] tgt, input logic rdy,
                                input logic v, input logic [31:0] pc, input logic [31:0] ins,
                                input logic flt, input logic [31:0] addr);
        vec_t r;
        r.rst = rst; r.en = en; r.rv = rv; r.tgt = tgt; r.rdy = rdy;
        r.v = v; r.pc = pc; r.ins = ins; r.flt = flt; r.addr = addr;
        return r;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%h want=%h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input logic rst, en, rv, input logic [31:0] tgt, input logic rdy);
        reset               = rst;
        bus.fetch_enable    = en;
        bus.redirect_valid  = rv;
        bus.redirect_target = tgt;
        bus.id_ready        = rdy;
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    int          pops;
    int          cyc;

    initial begin
        total = 0;
        bad   = 0;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Inputs are applied during the row's cycle; expectations describe
        // the outputs visible in that same cycle (result of earlier edges).
        // Reset, then free-running fetch with decode always ready
        tbl.push_back(mk(1,1,0,0,1, 0,32'h0,32'h0,0,32'h1000));
        tbl.push_back(mk(1,1,0,0,1, 0,32'h0,32'h0,0,32'h1000));
        tbl.push_back(mk(1,1,0,0,1, 0,32'h0,32'h0,0,32'h1000));
        tbl.push_back(mk(0,1,0,0,1, 0,32'h0,32'h0,0,32'h1000));
        tbl.push_back(mk(0,1,0,0,1, 1,32'h1000,imem(32'h1000),0,32'h1004));
        tbl.push_back(mk(0,1,0,0,1, 1,32'h1004,imem(32'h1004),0,32'h1008));
        tbl.push_back(mk(0,1,0,0,1, 1,32'h1008,imem(32'h1008),0,32'h100C));
        // Reset again, then decode stalled 5 cycles: buffer saturates at 2
        tbl.push_back(mk(1,1,0,0,1, 1,32'h100C,imem(32'h100C),0,32'h1010));
        tbl.push_back(mk(1,1,0,0,0, 0,32'h0,32'h0,0,32'h1000));
        tbl.push_back(mk(0,1,0,0,0, 0,32'h0,32'h0,0,32'h1000));
        tbl.push_back(mk(0,1,0,0,0, 1,32'h1000,imem(32'h1000),0,32'h1004));
        tbl.push_back(mk(0,1,0,0,0, 1,32'h1000,imem(32'h1000),0,32'h1008));
        tbl.push_back(mk(0,1,0,0,0, 1,32'h1000,imem(32'h1000),0,32'h1008));
        tbl.push_back(mk(0,1,0,0,0, 1,32'h1000,imem(32'h1000),0,32'h1008));
        tbl.push_back(mk(0,1,0,0,1, 1,32'h1000,imem(32'h1000),0,32'h1008));
        tbl.push_back(mk(0,1,0,0,1, 1,32'h1004,imem(32'h1004),0,32'h100C));
        // Redirect to 1040 with the buffer full
        tbl.push_back(mk(0,1,1,32'h1040,1, 1,32'h1008,imem(32'h1008),0,32'h1010));
        tbl.push_back(mk(0,1,0,0,1, 0,32'h1008,imem(32'h1008),0,32'h1040));
        tbl.push_back(mk(0,1,0,0,1, 1,32'h1040,imem(32'h1040),0,32'h1044));
        // Misaligned redirect to 1042, stay in fault, recover via 1000
        tbl.push_back(mk(0,1,1,32'h1042,1, 1,32'h1044,imem(32'h1044),0,32'h1048));
        tbl.push_back(mk(0,1,0,0,1, 0,32'h1044,imem(32'h1044),1,32'h1048));
        tbl.push_back(mk(0,1,0,0,1, 0,32'h1044,imem(32'h1044),1,32'h1048));
        tbl.push_back(mk(0,1,1,32'h1000,1, 0,32'h1044,imem(32'h1044),1,32'h1048));
        tbl.push_back(mk(0,1,0,0,1, 0,32'h1044,imem(32'h1044),0,32'h1000));
        // Redirect to the top of the address space: PC wraps to 0
        tbl.push_back(mk(0,1,1,32'hFFFFFFFC,1, 1,32'h1000,imem(32'h1000),0,32'h1004));
        tbl.push_back(mk(0,1,0,0,1, 0,32'h1000,imem(32'h1000),0,32'hFFFFFFFC));
        tbl.push_back(mk(0,1,0,0,1, 1,32'hFFFFFFFC,imem(32'hFFFFFFFC),0,32'h0));
        // Fill to two entries, reset; then fault, reset
        tbl.push_back(mk(0,1,0,0,0, 1,32'h0,imem(32'h0),0,32'h4));
        tbl.push_back(mk(1,1,0,0,0, 1,32'h0,imem(32'h0),0,32'h8));
        tbl.push_back(mk(0,1,1,32'h2,1, 0,32'h0,32'h0,0,32'h1000));
        tbl.push_back(mk(1,1,0,0,1, 0,32'h0,32'h0,1,32'h1000));
        tbl.push_back(mk(0,0,0,0,1, 0,32'h0,32'h0,0,32'h1000));

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            drive(tbl[i].rst, tbl[i].en, tbl[i].rv, tbl[i].tgt, tbl[i].rdy);
            #3;
            chk("id_valid",       i, 32'(bus.id_valid),    32'(tbl[i].v));
            chk("id_pc",          i, bus.id_pc,            tbl[i].pc);
            chk("id_instruction", i, bus.id_instruction,   tbl[i].ins);
            chk("fetch_fault",    i, 32'(bus.fetch_fault), 32'(tbl[i].flt));
            chk("imem_address",   i, bus.imem_address,     tbl[i].addr);
        end

        // Random fetch_enable / id_ready stream from boot: every accepted
        // instruction must be the next sequential PC, no gaps or repeats.
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        exp_pc = 32'h1000;
        for (int k = 0; k < 64; k++) begin
            exp_q.push_back(exp_pc);
            exp_pc = exp_pc + 32'd4;
        end
        pops = 0;
        cyc  = 0;
        while (pops < 60 && cyc < 1000) begin
            @(posedge clk);
            #1;
            drive(1'b0, ($urandom_range(0, 3) != 0), 1'b0, 32'h0, ($urandom_range(0, 2) != 0));
            #3;
            cyc++;
            if (bus.id_valid && bus.id_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream_underflow", cyc, 32'd1, 32'd0);
                end else begin
                    exp_pc = exp_q.pop_front();
                    chk("stream_pc",  cyc, bus.id_pc,          exp_pc);
                    chk("stream_ins", cyc, bus.id_instruction, imem(exp_pc));
                    pops++;
                end
            end
        end
        chk("stream_done", cyc, 32'(pops), 32'd60);
        chk("stream_fault", cyc, 32'(bus.fetch_fault), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
